ws2812_decoder: RTL and testbench
=================================

Name: ws2812_decoder

Overview:
- Receive end of the WS2812B single-wire protocol that led_driver transmits.
- Samples a strand line, classifies each bit by its high time, and assembles 24-bit GRB pixels, MSB first.
- Emits one color_valid pulse per pixel, with the pixel's index, and flags frame end when the line stays low for the reset period.
- Used as an on-chip loopback checker for led_driver and as a strip emulator.

Parameters:
- NUM_LEDS, 20, pixels per frame; sets led_index width $clog2(NUM_LEDS) and the overflow limit.
- BIT_THRESHOLD_CYCLES, 60, high time ≥ this is a 1, below it is a 0 (at 100 MHz, between 40 and 80).
- MIN_HIGH_CYCLES, 10, high pulses shorter than this are glitches and are ignored.
- MAX_HIGH_CYCLES, 120, high pulses longer than this are an error.
- RESET_CYCLES, 5000, low time that ends a frame (50 us at 100 MHz).

Ports:
- clk_in, input, 1, 100 MHz clock.
- rst_n, input, 1, asynchronous active-low reset.
- strand_in, input, 1, asynchronous WS2812B data line.
- green_out, output, 8, pixel green byte.
- red_out, output, 8, pixel red byte.
- blue_out, output, 8, pixel blue byte.
- color_valid, output, 1, single-cycle pulse; the color bytes and led_index are valid in that cycle.
- led_index, output, $clog2(NUM_LEDS), index of the pixel just decoded (0-based).
- frame_done, output, 1, single-cycle pulse at the reset-period detection.
- bit_error, output, 1, single-cycle pulse on an over-long high pulse.
- frame_error, output, 1, single-cycle pulse together with frame_done when the frame ended with a partial pixel.
- overflow, output, 1, sticky; set when a pixel beyond NUM_LEDS arrives, cleared at frame_done.

Behaviour:
- Reset (rst_n low, async): all outputs 0, counters 0, shift register 0, state WAIT_RESET.
- Synchronizer and edge detect:
  - strand_in passes through a 2-FF synchronizer; s_line is the second FF output.
  - Rising and falling edges are detected against a third registered copy.
  - All timing below counts in cycles of s_line.
- States:
  - WAIT_RESET: ignore data until s_line has been low for RESET_CYCLES consecutive cycles, then go to IDLE. No frame_done is issued for this first detection.
  - IDLE: line low. A rising edge clears high_cnt and goes to HIGH.
  - HIGH: high_cnt increments each cycle, saturating at MAX_HIGH_CYCLES+1. On a falling edge, classify the bit:
    - high_cnt < MIN_HIGH_CYCLES: glitch, discarded, shift register unchanged.
    - high_cnt > MAX_HIGH_CYCLES: bit_error pulse, partial pixel discarded, go to WAIT_RESET.
    - otherwise: bit = (high_cnt ≥ BIT_THRESHOLD_CYCLES); shift into the LSB of the 24-bit register and increment bit_cnt (0..23).
    - Then clear low_cnt and go to LOW.
  - LOW: low_cnt increments, saturating at RESET_CYCLES.
    - Rising edge before saturation: clear high_cnt, go to HIGH.
    - low_cnt reaching RESET_CYCLES: end of frame, go to IDLE.
- high_cnt is counted so that a high time of N cycles on s_line gives N at classification.
- Pixel output:
  - When the 24th bit is shifted in at cycle t, color_valid pulses at t+1.
  - green_out = sr[23:16], red_out = sr[15:8], blue_out = sr[7:0].
  - led_index = pix_cnt, which then increments; bit_cnt returns to 0.
  - The color outputs hold their value until the next pixel.
- Overflow: a pixel completing with pix_cnt == NUM_LEDS is dropped (no color_valid) and overflow is set.
- End of frame (low_cnt reaching RESET_CYCLES, entered from LOW):
  - frame_done pulses.
  - frame_error pulses in the same cycle if bit_cnt ≠ 0.
  - bit_cnt, pix_cnt and overflow clear.
- Simultaneous events:
  - Glitch classification has priority over the threshold.
  - A frame end and a new rising edge cannot coincide, because frame end requires the line low.
- Mid-operation reset: async clear of everything; the decoder must see a full reset period before decoding.

Decomposition:
- Package ws2812_pkg: default timing constants (T0H/T1H/RESET cycles at 100 MHz), a GRB struct typedef (3×8 bits), and a decoder state enum. led_driver will share these.
- One sub-module: sync_edge_detect, containing the 2-FF synchronizer, the delayed copy, and the rise/fall pulses.

Test Plan:
- Common setup: hold the line low for 5000 cycles, then start.
- Single pixel 0xA5 (G), 0x3C (R), 0xFF (B) with 40/85 and 80/45 cycle bits, then a 5000-cycle low → one color_valid with those bytes and led_index=0, followed by frame_done.
- Threshold boundary: high times of 59 vs 60 cycles → decoded 0 vs 1; a 9-cycle glitch → ignored, and the pixel still decodes correctly.
- Reset-period boundary: 4999 low cycles then more bits → no frame_done and decoding continues; 5000 low cycles → frame_done.
- Partial frame: 10 bits then reset low → no color_valid; frame_done and frame_error together.
- Overflow: 21 pixels with NUM_LEDS=20 → color_valid for indices 0..19 only; overflow set, then cleared at frame_done.
- Error and reset: a 150-cycle high pulse → bit_error, and no decoding until the next reset period. Separately, assert rst_n mid-pixel → all outputs 0 immediately, and decoding resumes only after a full reset low period.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812B timing constants, pixel type and decoder state encoding.
// Used by ws2812_decoder and intended to be shared with led_driver.
package ws2812_pkg;

    localparam int CLK_HZ              = 100_000_000;
    localparam int T0H_CYCLES          = 40;
    localparam int T0L_CYCLES          = 85;
    localparam int T1H_CYCLES          = 80;
    localparam int T1L_CYCLES          = 45;
    localparam int RESET_CYCLES_DEF    = 5000;
    localparam int BIT_THRESHOLD_DEF   = 60;
    localparam int MIN_HIGH_DEF        = 10;
    localparam int MAX_HIGH_DEF        = 120;
    localparam int PIXEL_BITS          = 24;

    typedef struct packed {
        logic [7:0] green;
        logic [7:0] red;
        logic [7:0] blue;
    } grb_t;

    typedef enum logic [1:0] {
        WAIT_RESET = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } dec_state_t;

    // Wire order on the strand is G, R, B with MSB first.
    function automatic grb_t unpack_grb(input logic [23:0] word);
        grb_t px;
        px.green = word[23:16];
        px.red   = word[15:8];
        px.blue  = word[7:0];
        return px;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for the strand line plus a delayed copy that
// yields single-cycle rise/fall pulses aligned with s_line.
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic s_line,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic line_reg;
    logic prev_reg;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            line_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= async_in;
            line_reg <= meta_reg;
            prev_reg <= line_reg;
        end
    end

    assign s_line = line_reg;
    assign rise   = line_reg & ~prev_reg;
    assign fall   = ~line_reg & prev_reg;

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812B receiver: classifies high pulses into bits, assembles GRB pixels,
// numbers them within a frame and reports frame end, errors and overflow.
module ws2812_decoder
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS             = 20,
    parameter int BIT_THRESHOLD_CYCLES = BIT_THRESHOLD_DEF,
    parameter int MIN_HIGH_CYCLES      = MIN_HIGH_DEF,
    parameter int MAX_HIGH_CYCLES      = MAX_HIGH_DEF,
    parameter int RESET_CYCLES         = RESET_CYCLES_DEF,
    localparam int IDX_W               = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             strand_in,
    output logic [7:0]       green_out,
    output logic [7:0]       red_out,
    output logic [7:0]       blue_out,
    output logic             color_valid,
    output logic [IDX_W-1:0] led_index,
    output logic             frame_done,
    output logic             bit_error,
    output logic             frame_error,
    output logic             overflow
);

    localparam int PIX_W  = $clog2(NUM_LEDS + 1);
    localparam int HCNT_W = $clog2(MAX_HIGH_CYCLES + 2);
    localparam int LCNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [HCNT_W-1:0] MIN_H   = HCNT_W'(MIN_HIGH_CYCLES);
    localparam logic [HCNT_W-1:0] MAX_H   = HCNT_W'(MAX_HIGH_CYCLES);
    localparam logic [HCNT_W-1:0] SAT_H   = HCNT_W'(MAX_HIGH_CYCLES + 1);
    localparam logic [HCNT_W-1:0] THR_H   = HCNT_W'(BIT_THRESHOLD_CYCLES);
    localparam logic [LCNT_W-1:0] RST_L   = LCNT_W'(RESET_CYCLES);
    localparam logic [LCNT_W-1:0] RST_LM1 = LCNT_W'(RESET_CYCLES - 1);
    localparam logic [PIX_W-1:0]  NUM_P   = PIX_W'(NUM_LEDS);
    localparam logic [4:0]        LAST_BIT = 5'd23;

    logic s_line;
    logic rise;
    logic fall;

    sync_edge_detect u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (strand_in),
        .s_line   (s_line),
        .rise     (rise),
        .fall     (fall)
    );

    dec_state_t        state_reg;
    logic [HCNT_W-1:0] high_cnt_reg;
    logic [LCNT_W-1:0] low_cnt_reg;
    logic [4:0]        bit_cnt_reg;
    logic [PIX_W-1:0]  pix_cnt_reg;
    // Only 23 bits are ever held: the 24th bit goes straight to the outputs.
    logic [22:0]       sr_reg;
    grb_t              color_reg;
    logic [IDX_W-1:0]  index_reg;
    logic              color_valid_reg;
    logic              frame_done_reg;
    logic              frame_error_reg;
    logic              bit_error_reg;
    logic              overflow_reg;

    logic              bit_value;
    logic [23:0]       shift_word;

    assign bit_value  = (high_cnt_reg >= THR_H);
    assign shift_word = {sr_reg, bit_value};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= WAIT_RESET;
            high_cnt_reg    <= '0;
            low_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
            pix_cnt_reg     <= '0;
            sr_reg          <= '0;
            color_reg       <= '0;
            index_reg       <= '0;
            color_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            bit_error_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            color_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            bit_error_reg   <= 1'b0;

            case (state_reg)
                WAIT_RESET: begin
                    if (s_line) begin
                        low_cnt_reg <= '0;
                    end else if (low_cnt_reg == RST_LM1) begin
                        // Silent resync: start a clean frame without frame_done.
                        low_cnt_reg  <= '0;
                        bit_cnt_reg  <= '0;
                        pix_cnt_reg  <= '0;
                        sr_reg       <= '0;
                        overflow_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        low_cnt_reg <= low_cnt_reg + 1'b1;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        // The rise cycle is the first high cycle, so start at 1.
                        high_cnt_reg <= {{(HCNT_W-1){1'b0}}, 1'b1};
                        state_reg    <= HIGH;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        // The fall cycle is already the first low cycle.
                        low_cnt_reg <= {{(LCNT_W-1){1'b0}}, 1'b1};
                        state_reg   <= LOW;
                        if (high_cnt_reg < MIN_H) begin
                            state_reg <= LOW;
                        end else if (high_cnt_reg > MAX_H) begin
                            bit_error_reg <= 1'b1;
                            bit_cnt_reg   <= '0;
                            sr_reg        <= '0;
                            state_reg     <= WAIT_RESET;
                        end else if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg <= '0;
                            sr_reg      <= '0;
                            if (pix_cnt_reg == NUM_P) begin
                                overflow_reg <= 1'b1;
                            end else begin
                                color_valid_reg <= 1'b1;
                                color_reg       <= unpack_grb(shift_word);
                                index_reg       <= pix_cnt_reg[IDX_W-1:0];
                                pix_cnt_reg     <= pix_cnt_reg + 1'b1;
                            end
                        end else begin
                            sr_reg      <= shift_word[22:0];
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (high_cnt_reg != SAT_H) begin
                        high_cnt_reg <= high_cnt_reg + 1'b1;
                    end
                end

                LOW: begin
                    if (rise) begin
                        high_cnt_reg <= {{(HCNT_W-1){1'b0}}, 1'b1};
                        state_reg    <= HIGH;
                    end else if (low_cnt_reg == RST_LM1) begin
                        low_cnt_reg     <= RST_L;
                        frame_done_reg  <= 1'b1;
                        frame_error_reg <= (bit_cnt_reg != 5'd0);
                        bit_cnt_reg     <= '0;
                        pix_cnt_reg     <= '0;
                        sr_reg          <= '0;
                        overflow_reg    <= 1'b0;
                        state_reg       <= IDLE;
                    end else begin
                        low_cnt_reg <= low_cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= WAIT_RESET;
            endcase
        end
    end

    assign green_out   = color_reg.green;
    assign red_out     = color_reg.red;
    assign blue_out    = color_reg.blue;
    assign led_index   = index_reg;
    assign color_valid = color_valid_reg;
    assign frame_done  = frame_done_reg;
    assign frame_error = frame_error_reg;
    assign bit_error   = bit_error_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Scoreboard bench for ws2812_decoder: stimulus pushes expected pixels and
// frame/bit events; a negedge monitor pops and compares on each DUT pulse.
module tb_ws2812_decoder;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       strand_in = 1'b0;
    logic [7:0] green_out, red_out, blue_out;
    logic       color_valid;
    logic [4:0] led_index;
    logic       frame_done, bit_error, frame_error, overflow;

    always #5 clk_in = ~clk_in;

    ws2812_decoder dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .strand_in   (strand_in),
        .green_out   (green_out),
        .red_out     (red_out),
        .blue_out    (blue_out),
        .color_valid (color_valid),
        .led_index   (led_index),
        .frame_done  (frame_done),
        .bit_error   (bit_error),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    typedef struct {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        int         idx;
    } pix_exp_t;

    pix_exp_t pix_q[$];
    bit       ferr_q[$];
    bit       berr_q[$];
    int       total = 0;
    int       bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic expect_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b, input int idx);
        pix_exp_t e;
        e.g = g; e.r = r; e.b = b; e.idx = idx;
        pix_q.push_back(e);
    endtask

    // MSB-first bits; optional long low after bit special_i, optional 9-cycle glitch after bit glitch_i.
    task automatic send_bits(input logic [23:0] d, input int n, input int h0, input int h1,
                             input int lo0, input int lo1, input int special_i,
                             input int special_low, input int glitch_i);
        for (int i = 23; i > 23 - n; i--) begin
            strand_in = 1'b1;
            cycles(d[i] ? h1 : h0);
            strand_in = 1'b0;
            cycles((i == special_i) ? special_low : (d[i] ? lo1 : lo0));
            if (i == glitch_i) begin
                strand_in = 1'b1;
                cycles(9);
                strand_in = 1'b0;
                cycles(50);
            end
        end
    endtask

    task automatic send_fast(input logic [23:0] d);
        send_bits(d, 24, 20, 65, 15, 15, -1, 0, -1);
    endtask

    task automatic end_frame(input bit err);
        ferr_q.push_back(err);
        strand_in = 1'b0;
        cycles(5005);
    endtask

    // Monitor: one line per DUT transaction, compared against the queues.
    initial begin
        forever begin
            pix_exp_t e;
            bit       fe;
            bit       be;
            @(negedge clk_in);
            if (color_valid) begin
                $display("pixel idx=%0d g=%h r=%h b=%h", led_index, green_out, red_out, blue_out);
                if (pix_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pixel: got idx=%0d g=%h r=%h b=%h required none",
                             led_index, green_out, red_out, blue_out);
                end else begin
                    e = pix_q.pop_front();
                    check("pix_green", {24'd0, green_out}, {24'd0, e.g});
                    check("pix_red",   {24'd0, red_out},   {24'd0, e.r});
                    check("pix_blue",  {24'd0, blue_out},  {24'd0, e.b});
                    check("pix_index", {27'd0, led_index}, e.idx);
                end
            end
            if (frame_done) begin
                $display("frame_done frame_error=%0b overflow=%0b", frame_error, overflow);
                if (ferr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame_done: got frame_done=1 required 0");
                end else begin
                    fe = ferr_q.pop_front();
                    check("frame_error", {31'd0, frame_error}, {31'd0, fe});
                end
            end else if (frame_error) begin
                total++; bad++;
                $display("FAIL stray_frame_error: got frame_error=1 without frame_done required 0");
            end
            if (bit_error) begin
                $display("bit_error");
                if (berr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_bit_error: got bit_error=1 required 0");
                end else begin
                    be = berr_q.pop_front();
                    check("bit_error", {31'd0, bit_error}, {31'd0, be});
                end
            end
        end
    end

    initial begin
        #20_000_000;
        bad++;
        $display("FAIL watchdog: got timeout required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] v;
        rst_n = 1'b0;
        strand_in = 1'b0;
        cycles(3);
        check("rst_color", {8'd0, green_out, red_out, blue_out}, 32'd0);
        check("rst_flags", {27'd0, color_valid, frame_done, bit_error, frame_error, overflow}, 32'd0);
        check("rst_index", {27'd0, led_index}, 32'd0);
        rst_n = 1'b1;
        cycles(5020);

        // Single pixel with nominal 40/85 and 80/45 bit timing.
        expect_pixel(8'hA5, 8'h3C, 8'hFF, 0);
        send_bits(24'hA53CFF, 24, 40, 80, 85, 45, -1, 0, -1);
        end_frame(1'b0);

        // 59 vs 60 cycle threshold, then a pixel with a 9-cycle glitch inside.
        expect_pixel(8'h0F, 8'hF0, 8'h55, 0);
        send_bits(24'h0FF055, 24, 59, 60, 30, 30, -1, 0, -1);
        expect_pixel(8'h12, 8'h34, 8'h56, 1);
        send_bits(24'h123456, 24, 40, 80, 30, 30, -1, 0, 12);
        end_frame(1'b0);

        // 4999 low cycles mid-pixel keep the frame; exactly 5000 end it.
        expect_pixel(8'hC3, 8'h96, 8'h01, 0);
        send_bits(24'hC39601, 24, 20, 65, 15, 15, 12, 4999, -1);
        expect_pixel(8'h5A, 8'h5A, 8'h5A, 1);
        ferr_q.push_back(1'b0);
        send_bits(24'h5A5A5A, 24, 20, 65, 15, 15, 0, 5000, -1);
        expect_pixel(8'h81, 8'h42, 8'h24, 0);
        send_fast(24'h814224);
        end_frame(1'b0);

        // Partial pixel: 10 bits then reset low.
        send_bits(24'hFFC000, 10, 20, 65, 15, 15, -1, 0, -1);
        end_frame(1'b1);

        // 21 pixels into a 20-LED frame.
        for (int i = 0; i < 21; i++) begin
            v = 8'(i);
            if (i < 20) expect_pixel(v, 8'h00, v, i);
            send_bits({v, 8'h00, v}, 24, 12, 62, 8, 8, -1, 0, -1);
        end
        cycles(5);
        check("overflow_set", {31'd0, overflow}, 32'd1);
        end_frame(1'b0);
        check("overflow_clear", {31'd0, overflow}, 32'd0);

        // Over-long high pulse, ignored bits, then recovery after a reset period.
        berr_q.push_back(1'b1);
        strand_in = 1'b1;
        cycles(150);
        strand_in = 1'b0;
        cycles(100);
        send_bits(24'hDEADBE, 8, 20, 65, 15, 15, -1, 0, -1);
        cycles(5020);
        expect_pixel(8'h11, 8'h22, 8'h33, 0);
        send_fast(24'h112233);
        end_frame(1'b0);

        // Reset mid-pixel: outputs clear at once, decoding waits for a reset period.
        send_bits(24'hABCDEF, 10, 20, 65, 15, 15, -1, 0, -1);
        strand_in = 1'b1;
        cycles(30);
        rst_n = 1'b0;
        #2;
        check("midrst_color", {8'd0, green_out, red_out, blue_out}, 32'd0);
        check("midrst_flags", {27'd0, color_valid, frame_done, bit_error, frame_error, overflow}, 32'd0);
        check("midrst_index", {27'd0, led_index}, 32'd0);
        strand_in = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        send_bits(24'h445566, 8, 20, 65, 15, 15, -1, 0, -1);
        cycles(5020);
        expect_pixel(8'h77, 8'h88, 8'h99, 0);
        send_fast(24'h778899);
        end_frame(1'b0);

        cycles(20);
        check("pix_q_drained",  pix_q.size(),  32'd0);
        check("ferr_q_drained", ferr_q.size(), 32'd0);
        check("berr_q_drained", berr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
